// File: rtl/cache_req_arbiter_pkg.sv
// Shared cache constants plus the request-arbiter state type and default sizing.
package cache_req_arbiter_pkg;

   localparam int CACHE_LINE_BYTES = 64;
   localparam int CACHE_WAYS       = 4;
   localparam int CACHE_SETS       = 256;

   localparam int ARB_N_REQ_DEFAULT  = 4;
   localparam int ARB_DATA_W_DEFAULT = 64;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/cache_req_arbiter_rr_picker.sv
// Combinational winner picker: first valid requester found searching upward from start, wrapping.
// A start of zero turns it into a lowest-index-wins priority encoder.
module rr_picker
   import cache_req_arbiter_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ_DEFAULT
) (
   input  logic [N_REQ-1:0]         valid,
   input  logic [$clog2(N_REQ)-1:0] start,
   output logic [$clog2(N_REQ)-1:0] index,
   output logic                     any_valid
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W:0] cand;

   // One extra bit on the candidate keeps the modulo-N wrap free of overflow.
   always_comb begin
      index     = '0;
      any_valid = 1'b0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, start} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N_REQ)) begin
            cand = cand - (IDX_W+1)'(N_REQ);
         end
         if (!any_valid && valid[cand[IDX_W-1:0]]) begin
            any_valid = 1'b1;
            index     = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cache_req_arbiter.sv
// Packet-locked N-way request arbiter feeding one shared downstream beat port.
// Fixed priority by default; define CACHE_ARB_RR_EN for round-robin arbitration.
module cache_req_arbiter
   import cache_req_arbiter_pkg::*;
#(
   parameter int N_REQ  = ARB_N_REQ_DEFAULT,
   parameter int DATA_W = ARB_DATA_W_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ-1:0][DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]             req_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_last,
   output logic [$clog2(N_REQ)-1:0]     grant_id,
   output logic                         busy
);
   localparam int ID_W = $clog2(N_REQ);

   arb_state_t      state;
   arb_state_t      state_next;
   logic [ID_W-1:0] grant_next;
   logic [ID_W-1:0] start;
   logic [ID_W-1:0] pick_index;
   logic            pick_any;
   logic            xfer_done;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .valid     (req_valid),
      .start     (start),
      .index     (pick_index),
      .any_valid (pick_any)
   );

   assign xfer_done = out_valid & out_ready & out_last;

`ifdef CACHE_ARB_RR_EN
   logic [ID_W-1:0] ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (xfer_done) begin
         ptr <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);
      end
   end

   assign start = ptr;
`else
   assign start = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ARB_IDLE;
         grant_id <= '0;
      end else begin
         state    <= state_next;
         grant_id <= grant_next;
      end
   end

   // The winner is only latched here; its first beat moves in the following LOCKED cycle.
   always_comb begin
      state_next = state;
      grant_next = grant_id;
      case (state)
         ARB_IDLE: begin
            if (pick_any) begin
               state_next = ARB_LOCKED;
               grant_next = pick_index;
            end
         end
         ARB_LOCKED: begin
            if (xfer_done) begin
               state_next = ARB_IDLE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == ARB_LOCKED);
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      req_ready = '0;
      if (busy) begin
         out_valid           = req_valid[grant_id];
         out_data            = req_data[grant_id];
         out_last            = req_last[grant_id];
         req_ready[grant_id] = out_ready;
      end
   end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter: arbitration-order vector table plus multi-cycle corner sequences.
// Expected grant orders follow the policy selected by CACHE_ARB_RR_EN.
module tb_cache_req_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;

`ifdef CACHE_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      logic [1:0]    id;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   // npkt: single-beat packets per requester (nibble i = requester i);
   // gfix/grr: expected grant order, first grant in the most significant used nibble.
   typedef struct {
      logic [15:0] npkt;
      int          ngrant;
      logic [31:0] gfix;
      logic [31:0] grr;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [N-1:0][DW-1:0] req_data;
   logic [N-1:0]         req_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [DW-1:0]        out_data;
   logic                 out_last;
   logic [1:0]           grant_id;
   logic                 busy;

   always #5 clk = ~clk;

   cache_req_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_last  (req_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] src_data [N][16];
   logic          src_last [N][16];
   logic [3:0]    head [N];
   logic [3:0]    tail [N];
   logic [N-1:0]  hold;
   logic [N-1:0]  drv_valid;
   beat_t         exp_q [$];
   logic [1:0]    grant_exp [$];
   logic          exp_busy;
   logic [1:0]    cur_grant;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic load_packet(input logic [1:0] id, input int nbeats, input logic [DW-1:0] base);
      for (int k = 0; k < nbeats; k++) begin
         beat_t b;
         b.id   = id;
         b.data = base + DW'(k);
         b.last = (k == nbeats - 1);
         src_data[id][tail[id]] = b.data;
         src_last[id][tail[id]] = b.last;
         tail[id] = tail[id] + 4'd1;
         exp_q.push_back(b);
      end
   endtask

   task automatic apply_stimulus(input logic ready);
      for (int i = 0; i < N; i++) begin
         drv_valid[i] = (head[i] != tail[i]) && !hold[i];
         req_data[i]  = src_data[i][head[i]];
         req_last[i]  = src_last[i][head[i]];
      end
      req_valid = drv_valid;
      out_ready = ready;
   endtask

   task automatic check_output();
      logic [N-1:0] exp_ready;
      logic         xfer;
      logic         next_busy;
      logic [1:0]   next_grant;
      int           idx;
      exp_ready = '0;
      if (exp_busy && out_ready) exp_ready[cur_grant] = 1'b1;
      xfer       = exp_busy && drv_valid[cur_grant] && out_ready;
      next_busy  = exp_busy;
      next_grant = cur_grant;
      check("busy", DW'(busy), DW'(exp_busy));
      check("out_valid", DW'(out_valid), DW'(exp_busy && drv_valid[cur_grant]));
      check("req_ready", DW'(req_ready), DW'(exp_ready));
      if (exp_busy) check("grant_id", DW'(grant_id), DW'(cur_grant));
      if (xfer) begin
         idx = -1;
         for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].id == cur_grant) idx = k;
         end
         if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard: beat from requester %0d, expected none pending", cur_grant);
         end else begin
            check("out_data", out_data, exp_q[idx].data);
            check("out_last", DW'(out_last), DW'(exp_q[idx].last));
            if (exp_q[idx].last) next_busy = 1'b0;
            exp_q.delete(idx);
         end
         head[cur_grant] = head[cur_grant] + 4'd1;
      end else if (!exp_busy && drv_valid != '0) begin
         if (grant_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL grant_order: arbitration with valid=%b, expected no arbitration", drv_valid);
         end else begin
            next_grant = grant_exp.pop_front();
            next_busy  = 1'b1;
         end
      end
      exp_busy  = next_busy;
      cur_grant = next_grant;
   endtask

   task automatic step(input logic ready);
      apply_stimulus(ready);
      #1;
      check_output();
      @(negedge clk);
   endtask

   task automatic run_drain(input int budget);
      int cnt;
      cnt = 0;
      while ((exp_q.size() != 0 || grant_exp.size() != 0 || exp_busy) && cnt < budget) begin
         step(1'b1);
         cnt++;
      end
      check("drain_beats", DW'(exp_q.size()), '0);
      check("drain_grants", DW'(grant_exp.size()), '0);
      check("drain_idle", DW'(exp_busy), '0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        vecs [7];
      logic [31:0] seq;
      int          np;

      vecs[0] = '{npkt: 16'h1112, ngrant: 5, gfix: 32'h00123, grr: 32'h01230};
      vecs[1] = '{npkt: 16'h1030, ngrant: 4, gfix: 32'h1113,  grr: 32'h1311};
      vecs[2] = '{npkt: 16'h1101, ngrant: 3, gfix: 32'h023,   grr: 32'h230};
      vecs[3] = '{npkt: 16'h1100, ngrant: 2, gfix: 32'h23,    grr: 32'h23};
      vecs[4] = '{npkt: 16'h1001, ngrant: 2, gfix: 32'h03,    grr: 32'h03};
      vecs[5] = '{npkt: 16'h0110, ngrant: 2, gfix: 32'h12,    grr: 32'h12};
      vecs[6] = '{npkt: 16'h1011, ngrant: 3, gfix: 32'h013,   grr: 32'h301};

      rst       = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      out_ready = 1'b0;
      hold      = '0;
      drv_valid = '0;
      exp_busy  = 1'b0;
      cur_grant = 2'd0;
      for (int i = 0; i < N; i++) begin
         head[i] = 4'd0;
         tail[i] = 4'd0;
         for (int k = 0; k < 16; k++) begin
            src_data[i][k] = '0;
            src_last[i][k] = 1'b0;
         end
      end

      #2;
      check("reset_busy", DW'(busy), '0);
      check("reset_out_valid", DW'(out_valid), '0);
      check("reset_req_ready", DW'(req_ready), '0);
      check("reset_grant_id", DW'(grant_id), '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Arbitration-order table: single-beat packets, downstream always ready.
      for (int r = 0; r < 7; r++) begin
         seq = RR ? vecs[r].grr : vecs[r].gfix;
         for (int i = 0; i < N; i++) begin
            np = int'(vecs[r].npkt[4*i +: 4]);
            for (int p = 0; p < np; p++) begin
               load_packet(i[1:0], 1, DW'(r * 4096 + i * 256 + p));
            end
         end
         for (int g = 0; g < vecs[r].ngrant; g++) begin
            grant_exp.push_back(seq[4*(vecs[r].ngrant-1-g) +: 2]);
         end
         run_drain(60);
      end

      // Three-beat packet under downstream backpressure; requester 0 arrives mid-packet.
      load_packet(2'd2, 3, 64'hA);
      grant_exp.push_back(2'd2);
      grant_exp.push_back(2'd0);
      step(1'b1);
      step(1'b1);
      load_packet(2'd0, 1, 64'hD0);
      step(1'b0);
      step(1'b1);
      step(1'b0);
      step(1'b1);
      run_drain(20);

      // Owner stalls for two cycles mid-packet: bubble, lock held.
      load_packet(2'd1, 3, 64'h5100);
      grant_exp.push_back(2'd1);
      step(1'b1);
      step(1'b1);
      hold[1] = 1'b1;
      step(1'b1);
      step(1'b1);
      hold[1] = 1'b0;
      run_drain(20);

      // Reset during beat 2 of a 4-beat packet, then re-arbitrate from a cleared pointer.
      load_packet(2'd3, 4, 64'h7300);
      grant_exp.push_back(2'd3);
      step(1'b1);
      step(1'b1);
      apply_stimulus(1'b1);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_busy", DW'(busy), '0);
      check("midrst_out_valid", DW'(out_valid), '0);
      check("midrst_req_ready", DW'(req_ready), '0);
      check("midrst_grant_id", DW'(grant_id), '0);
      exp_q.delete();
      grant_exp.delete();
      head[3]   = tail[3];
      exp_busy  = 1'b0;
      cur_grant = 2'd0;
      @(negedge clk);
      rst = 1'b1;
      load_packet(2'd0, 1, 64'h8000);
      load_packet(2'd3, 1, 64'h8300);
      grant_exp.push_back(2'd0);
      grant_exp.push_back(2'd3);
      run_drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_req_arbiter.md
CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requester channels (2..8).
REQ-002 Parameter DATA_W, default 64, payload width per beat.
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  N_REQ  per-requester beat valid.
REQ-006 Port req_ready  output  N_REQ  per-requester beat accepted.
REQ-007 Port req_data  input  N_REQ x DATA_W  per-requester payload.
REQ-008 Port req_last  input  N_REQ  marks final beat of a packet.
REQ-009 Port out_valid  output  1  shared downstream beat valid.
REQ-010 Port out_ready  input  1  downstream accepts beat.
REQ-011 Port out_data  output  DATA_W  muxed payload.
REQ-012 Port out_last  output  1  muxed last flag.
REQ-013 Port grant_id  output  clog2(N_REQ)  index of current owner; valid only when busy=1.
REQ-014 Port busy  output  1  high while a packet owns the output.

Function
REQ-015 FSM states: IDLE, LOCKED.
REQ-016 IDLE: if any req_valid, picker selects winner, winner registered into grant_id, next state LOCKED; no beat transferred in IDLE cycle (1-cycle arbitration latency).
REQ-017 IDLE: all req_ready=0, out_valid=0, busy=0.
REQ-018 LOCKED: out_valid=req_valid[grant_id], out_data=req_data[grant_id], out_last=req_last[grant_id], req_ready[grant_id]=out_ready, all other req_ready=0, busy=1.
REQ-019 Beat transfer occurs when out_valid && out_ready; transfer with out_last=1 returns FSM to IDLE next cycle.
REQ-020 Ownership held for whole packet; owner dropping req_valid mid-packet keeps LOCKED with out_valid=0 (bubble), no re-arbitration.
REQ-021 out_valid shall not depend combinationally on out_ready.
REQ-022 Back-to-back packets: minimum one IDLE cycle between last beat and next packet's first beat.
REQ-023 Non-granted requesters' valid/data shall not affect outputs.
REQ-024 Single-beat packet (req_last=1 on first beat) legal: LOCKED lasts exactly until that beat transfers.

Reset
REQ-025 On rst=0, immediately: state IDLE, grant_id=0, priority pointer=0, busy=0, out_valid=0, all req_ready=0.
REQ-026 Reset mid-packet abandons packet; no partial-packet completion after reset release.
REQ-027 First arbitration after reset release occurs no earlier than first rising edge with rst=1.

Configuration
REQ-028 Macro CACHE_ARB_RR_EN selects policy.
REQ-029 With CACHE_ARB_RR_EN defined: round-robin; search starts at pointer; on packet completion pointer = grant_id+1, wrapping N_REQ-1 -> 0.
REQ-030 Without CACHE_ARB_RR_EN: fixed priority, lowest index wins; pointer register not instantiated.

Structure
REQ-031 Shared package holds arbiter FSM state typedef and N_REQ/DATA_W defaults alongside existing cache constants.
REQ-032 Winner selection in sub-module rr_picker (valid vector + start pointer -> one-hot/index + any_valid), purely combinational.
REQ-033 Output mux and FSM in cache_req_arbiter; estimated 150-250 RTL lines total.

Verification
REQ-034 RR, N_REQ=4, req_valid=4'b1111 single-beat, out_ready=1 -> grants 0,1,2,3,0 in order, each beat separated by one IDLE cycle.
REQ-035 Fixed priority (macro undefined), req_valid=4'b1010 continuous -> grant_id always 1; requester 3 never served.
REQ-036 Requester 2 sends 3-beat packet 0xA,0xB,0xC, out_ready toggles 1,0,1,0,1 -> out_data sequence A,B,C, no beat duplicated/lost, requester 0 asserting valid mid-packet gets req_ready=0 until packet ends.
REQ-037 Owner drops req_valid for 2 cycles mid-packet -> out_valid=0 those cycles, busy=1, grant_id unchanged, packet resumes.
REQ-038 rst asserted during beat 2 of 4 -> same cycle outputs zero, state IDLE; after release, RR pointer=0, requester 0 wins if valid.
REQ-039 RR wrap: grant requester 3 last, then req_valid=4'b1001 -> requester 0 wins.
